// File: rtl/md_pkg.sv
// md_pkg: shared md_op encodings, FSM states and op classification for md_unit.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MD_UNIT_MADD_EN.
package md_pkg;
    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MTHI  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;
    localparam logic [3:0] MD_MADD  = 4'd6;
    localparam logic [3:0] MD_MADDU = 4'd7;
    localparam logic [3:0] MD_MSUB  = 4'd8;
    localparam logic [3:0] MD_MSUBU = 4'd9;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Ops that take the MULT_CYCLES latency; the accumulate family only exists when enabled.
    function automatic logic md_is_mul(input logic [3:0] op);
`ifdef MD_UNIT_MADD_EN
        return op == MD_MULT || op == MD_MULTU || op == MD_MADD || op == MD_MADDU ||
               op == MD_MSUB || op == MD_MSUBU;
`else
        return op == MD_MULT || op == MD_MULTU;
`endif
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational signed/unsigned multiply, divide and multiply-accumulate.
// Result is {hi,lo}; for divides that is {remainder, quotient}.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [WIDTH-1:0]   i_hi,
    input  logic [WIDTH-1:0]   i_lo,
    output logic [2*WIDTH-1:0] o_res,
    output logic               o_dz
);
    logic               w_sgn, w_udiv;
    logic [2*WIDTH-1:0] w_sa, w_sb, w_prod, w_acc;
    logic [WIDTH-1:0]   w_ma, w_mb, w_bd, w_uq, w_ur, w_q, w_r;

    assign w_sgn  = i_op == MD_MULT || i_op == MD_MADD || i_op == MD_MSUB;
    assign w_sa   = w_sgn ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
    assign w_sb   = w_sgn ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
    assign w_prod = w_sa * w_sb;
    assign w_acc  = {i_hi, i_lo};

    // Signed divide on magnitudes: avoids the most-negative / -1 overflow, which
    // naturally wraps back to the dividend with a zero remainder.
    assign w_udiv = i_op == MD_DIVU;
    assign w_ma   = (!w_udiv && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mb   = (!w_udiv && i_b[WIDTH-1]) ? -i_b : i_b;
    assign o_dz   = i_b == '0;
    assign w_bd   = o_dz ? WIDTH'(1) : w_mb;
    assign w_uq   = w_ma / w_bd;
    assign w_ur   = w_ma % w_bd;
    assign w_q    = (!w_udiv && (i_a[WIDTH-1] ^ i_b[WIDTH-1])) ? -w_uq : w_uq;
    assign w_r    = (!w_udiv && i_a[WIDTH-1]) ? -w_ur : w_ur;

    // Select the 2*WIDTH result for the requested operation.
    always_comb begin
        o_res = (i_op == MD_DIV || i_op == MD_DIVU)   ? {w_r, w_q} :
                (i_op == MD_MADD || i_op == MD_MADDU) ? w_acc + w_prod :
                (i_op == MD_MSUB || i_op == MD_MSUBU) ? w_acc - w_prod : w_prod;
    end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers and hazard stall.
// Define MD_UNIT_MADD_EN to accept the MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [0:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_res;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [2*WIDTH-1:0] w_res;
    logic               w_dz, w_mul, w_div;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .i_op  (md_op),
        .i_a   (a),
        .i_b   (b),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .o_res (w_res),
        .o_dz  (w_dz)
    );

    assign w_mul = md_is_mul(md_op);
    assign w_div = md_is_div(md_op);
    assign busy  = r_state == RUN;
    assign stall = busy | (start & (w_mul | w_div));
    assign hi    = r_hi;
    assign lo    = r_lo;

    // Issue latches the full result; RUN counts down and commits on the last edge.
    // Starts while busy are dropped; divide-by-zero commits nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_res   <= '0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_state <= IDLE;
                if (!r_dz) {r_hi, r_lo} <= r_res;
            end
        end else if (start) begin
            if (w_mul | w_div) begin
                r_state <= RUN;
                r_cnt   <= w_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                r_res   <= w_res;
                r_dz    <= w_div & w_dz;
            end else if (md_op == MD_MTHI) begin
                r_hi <= a;
            end else if (md_op == MD_MTLO) begin
                r_lo <= a;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table-driven scoreboard bench for md_unit plus hand-written corner sequences.
module tb_md_unit;
    import md_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
        int          cyc;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] a = '0, b = '0, hi, lo;
    logic        busy, stall;

    int          tests = 0, fails = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    exp_t        sb[$];
    vec_t        tv[16];

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .stall (stall),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issue one op, count busy cycles, then compare committed HI/LO from the scoreboard.
    task automatic run_op(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] eh, input logic [31:0] el, input int cyc,
                          input string nm);
        int   n;
        exp_t e;
        @(negedge clk);
        start = 1'b1; md_op = op; a = va; b = vb;
        #1 check({nm, " stall@issue"}, 32'(stall), 32'(cyc != 0));
        sb.push_back('{eh, el});
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 1) begin
                check({nm, " hi_hold"}, hi, m_hi);
                check({nm, " lo_hold"}, lo, m_lo);
                check({nm, " stall_busy"}, 32'(stall), 32'd1);
            end
            @(negedge clk);
        end
        check({nm, " cycles"}, 32'(n), 32'(cyc));
        e = sb.pop_front();
        check({nm, " hi"}, hi, e.hi);
        check({nm, " lo"}, lo, e.lo);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        int          n;
        logic [31:0] ra, rb;
        logic [63:0] p;
        longint      sa, sb_;

        tv[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5,  "mult_m1x2"};
        tv[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 5,  "multu_ffx2"};
        tv[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_m7d2"};
        tv[3]  = '{MD_DIVU,  32'h7,        32'h2,        32'h00000001, 32'h00000003, 10, "divu_7d2"};
        tv[4]  = '{MD_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h00000003, 0,  "mthi"};
        tv[5]  = '{MD_MTLO,  32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0,  "mtlo"};
        tv[6]  = '{MD_DIVU,  32'h55,       32'h0,        32'h12345678, 32'h9ABCDEF0, 10, "divu_by0"};
        tv[7]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, "div_min_m1"};
        tv[8]  = '{MD_DIV,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, "div_7dm2"};
        tv[9]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5,  "mult_minsq"};
        tv[10] = '{4'hF,     32'hDEADBEEF, 32'h3,        32'h40000000, 32'h00000000, 0,  "unknown_op"};
        tv[11] = '{MD_DIV,   32'hFFFFFFF8, 32'h0,        32'h40000000, 32'h00000000, 10, "div_by0"};
        for (int i = 12; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i[0]) begin
                p = {32'b0, ra} * {32'b0, rb};
                tv[i] = '{MD_MULTU, ra, rb, p[63:32], p[31:0], 5, "multu_rand"};
            end else begin
                sa  = longint'(signed'(ra));
                sb_ = longint'(signed'(rb));
                p   = 64'(sa * sb_);
                tv[i] = '{MD_MULT, ra, rb, p[63:32], p[31:0], 5, "mult_rand"};
            end
        end

        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++)
            run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, tv[i].cyc, tv[i].name);

        // Start with div on busy cycle 3 of a mult must be ignored.
        @(negedge clk);
        start = 1'b1; md_op = MD_MULT; a = 32'd3; b = 32'd5;
        #1 check("ign stall@issue", 32'(stall), 32'd1);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            check("ign stall_busy", 32'(stall), 32'd1);
            check("ign hi_hold", hi, m_hi);
            if (n == 3) begin
                start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ign cycles", 32'(n), 32'd5);
        check("ign hi", hi, 32'd0);
        check("ign lo", lo, 32'd15);
        repeat (12) @(negedge clk);
        check("ign busy_after", 32'(busy), 32'd0);
        check("ign hi_after", hi, 32'd0);
        check("ign lo_after", lo, 32'd15);

        // Reset on busy cycle 4 of a div aborts it and clears HI/LO.
        @(negedge clk);
        start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy_c4", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("abort busy_after", 32'(busy), 32'd0);
        check("abort hi_after", hi, 32'd0);
        check("abort lo_after", lo, 32'd0);
        m_hi = '0;
        m_lo = '0;

        run_op(MD_MTLO, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 0, "mtlo_pre");
`ifdef MD_UNIT_MADD_EN
        run_op(MD_MADD, 32'h1, 32'h1, 32'h00000001, 32'h00000000, 5, "madd");
        run_op(MD_MSUB, 32'h1, 32'h1, 32'h00000000, 32'hFFFFFFFF, 5, "msub");
`else
        run_op(MD_MADD, 32'h1, 32'h1, 32'h00000000, 32'hFFFFFFFF, 0, "madd_off");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
